// File: rtl/bit_position_decoder_pkg.sv
// Shared constants, state encoding and the lowest-set-bit helper for the
// bit position decoder.
package bit_position_decoder_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_POS_W = 6;

   // Position code meaning "no bit set"; equal to the word width.
   localparam logic [DEFAULT_POS_W-1:0] NO_BIT = DEFAULT_POS_W'(DEFAULT_WIDTH);

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   function automatic logic [DEFAULT_POS_W-1:0] lowest_set(input logic [DEFAULT_WIDTH-1:0] w);
      logic [DEFAULT_POS_W-1:0] r;
      r = NO_BIT;
      for (int i = DEFAULT_WIDTH - 1; i >= 0; i--) begin
         if (w[i]) r = DEFAULT_POS_W'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/bit_position_decoder_if.sv
// Beat input and word output handshake bundle of the bit position decoder.
// Both sides are valid/ready: a transfer happens on a rising edge where valid and
// ready are both 1; valid holds its payload until that edge, ready may change freely.
interface bit_position_decoder_if #(
   parameter int WIDTH = 32,
   parameter int POS_W = 6
);
   logic             in_valid;
   logic             in_ready;
   logic [POS_W-1:0] in_pos;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_word;
   logic [POS_W-1:0] out_min_pos;
   logic [POS_W-1:0] out_count;
   logic             out_dup;
   logic             out_range_err;

   modport master (
      output in_valid, in_pos, in_last, out_ready,
      input  in_ready, out_valid, out_word, out_min_pos, out_count, out_dup, out_range_err
   );

   modport slave (
      input  in_valid, in_pos, in_last, out_ready,
      output in_ready, out_valid, out_word, out_min_pos, out_count, out_dup, out_range_err
   );
endinterface

// File: rtl/bit_position_decoder.sv
// Assembles a word from a stream of bit-position beats, then holds it with its
// lowest set position, distinct-bit count and duplicate/range flags until taken.
module bit_position_decoder
   import bit_position_decoder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int POS_W = DEFAULT_POS_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   bit_position_decoder_if.slave bus,
   output state_t                state
);

   localparam int IDX_W = $clog2(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] word_q;
   logic [POS_W-1:0] count_q;
   logic             dup_q;
   logic             range_q;
   logic             accept;
   logic             take;
   logic [IDX_W-1:0] idx;

   assign accept = bus.in_valid && (state_q == ACCUM);
   assign take   = bus.out_ready && (state_q == HOLD);
   assign idx    = bus.in_pos[IDX_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ACCUM;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state_q)
         ACCUM: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid && bus.in_last) state_d = HOLD;
         end
         HOLD: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_d = ACCUM;
         end
         default: state_d = ACCUM;
      endcase
   end

   // Positions below NO_BIT are data, NO_BIT itself is the empty marker,
   // anything above is flagged but otherwise ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_q  <= '0;
         count_q <= '0;
         dup_q   <= 1'b0;
         range_q <= 1'b0;
      end else if (take) begin
         word_q  <= '0;
         count_q <= '0;
         dup_q   <= 1'b0;
         range_q <= 1'b0;
      end else if (accept) begin
         if (bus.in_pos < NO_BIT) begin
            if (word_q[idx]) begin
               dup_q <= 1'b1;
            end else begin
               word_q[idx] <= 1'b1;
               count_q     <= count_q + POS_W'(1);
            end
         end else if (bus.in_pos > NO_BIT) begin
            range_q <= 1'b1;
         end
      end
   end

   // The minimum of all set positions is exactly the lowest set bit of the word.
   assign bus.out_word      = word_q;
   assign bus.out_min_pos   = lowest_set(word_q);
   assign bus.out_count     = count_q;
   assign bus.out_dup       = dup_q;
   assign bus.out_range_err = range_q;
   assign state             = state_q;

endmodule

// File: tb/tb_bit_position_decoder.sv
// Directed vector bench for bit_position_decoder.
module tb_bit_position_decoder;
   import bit_position_decoder_pkg::*;

   logic   clk;
   logic   rst_n;
   state_t dbg_state;
   int     total;
   int     bad;
   logic [31:0] exp_q[$];

   bit_position_decoder_if #(.WIDTH(32), .POS_W(6)) bus ();

   bit_position_decoder #(.WIDTH(32), .POS_W(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave),
      .state (dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int          n;
      logic [5:0]  pos[3];
      logic [31:0] word;
      logic [5:0]  min_pos;
      logic [5:0]  count;
      logic        dup;
      logic        rng;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // driver: one beat, presented on a falling edge, retired on the next
   task automatic send_beat(input logic [5:0] pos, input logic last);
      int k;
      k = 0;
      while (bus.in_ready !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
      bus.in_valid = 1'b1;
      bus.in_pos   = pos;
      bus.in_last  = last;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
      check({tag, "_in_ready"},  {31'd0, bus.in_ready},  32'd1);
      check({tag, "_word"},      bus.out_word,           32'd0);
      check({tag, "_min"},       {26'd0, bus.out_min_pos}, 32'd32);
      check({tag, "_count"},     {26'd0, bus.out_count}, 32'd0);
      check({tag, "_dup"},       {31'd0, bus.out_dup},   32'd0);
      check({tag, "_rng"},       {31'd0, bus.out_range_err}, 32'd0);
   endtask

   // scoreboard: word from the expected queue plus side fields
   task automatic check_held(input string tag, input logic [5:0] min_pos,
                             input logic [5:0] count, input logic dup, input logic rng);
      logic [31:0] w;
      w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hdead_beef;
      check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd1);
      check({tag, "_in_ready"},  {31'd0, bus.in_ready},  32'd0);
      check({tag, "_state"},     {31'd0, dbg_state},     {31'd0, HOLD});
      check({tag, "_word"},      bus.out_word,           w);
      check({tag, "_min"},       {26'd0, bus.out_min_pos}, {26'd0, min_pos});
      check({tag, "_count"},     {26'd0, bus.out_count}, {26'd0, count});
      check({tag, "_dup"},       {31'd0, bus.out_dup},   {31'd0, dup});
      check({tag, "_rng"},       {31'd0, bus.out_range_err}, {31'd0, rng});
   endtask

   task automatic take_word(input string tag);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check_idle({tag, "_clr"});
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_pos    = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;

      vecs[0] = '{n: 2, pos: '{6'd12, 6'd28, 6'd0}, word: 32'h1000_1000, min_pos: 6'd12, count: 6'd2, dup: 1'b0, rng: 1'b0};
      vecs[1] = '{n: 3, pos: '{6'd28, 6'd4, 6'd12}, word: 32'h1000_1010, min_pos: 6'd4, count: 6'd3, dup: 1'b0, rng: 1'b0};
      vecs[2] = '{n: 1, pos: '{6'd32, 6'd0, 6'd0}, word: 32'h0000_0000, min_pos: 6'd32, count: 6'd0, dup: 1'b0, rng: 1'b0};
      vecs[3] = '{n: 2, pos: '{6'd5, 6'd5, 6'd0}, word: 32'h0000_0020, min_pos: 6'd5, count: 6'd1, dup: 1'b1, rng: 1'b0};
      vecs[4] = '{n: 2, pos: '{6'd40, 6'd0, 6'd0}, word: 32'h0000_0001, min_pos: 6'd0, count: 6'd1, dup: 1'b0, rng: 1'b1};
      vecs[5] = '{n: 3, pos: '{6'd31, 6'd0, 6'd33}, word: 32'h8000_0001, min_pos: 6'd0, count: 6'd2, dup: 1'b0, rng: 1'b1};

      #2;
      check_idle("reset");
      check("reset_state", {31'd0, dbg_state}, {31'd0, ACCUM});
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 6; v++) begin
         exp_q.push_back(vecs[v].word);
         for (int b = 0; b < vecs[v].n; b++)
            send_beat(vecs[v].pos[b], b == vecs[v].n - 1);
         check_held($sformatf("vec%0d", v), vecs[v].min_pos, vecs[v].count, vecs[v].dup, vecs[v].rng);
         take_word($sformatf("vec%0d", v));
      end

      // stall in HOLD for 3 cycles with a beat offered, then take
      exp_q.push_back(32'h1000_1000);
      send_beat(6'd12, 1'b0);
      send_beat(6'd28, 1'b1);
      bus.in_valid = 1'b1;
      bus.in_pos   = 6'd3;
      for (int c = 0; c < 3; c++) begin
         exp_q.push_back(32'h1000_1000);
         check_held($sformatf("stall%0d", c), 6'd12, 6'd2, 1'b0, 1'b0);
         @(negedge clk);
      end
      check_held("stall3", 6'd12, 6'd2, 1'b0, 1'b0);
      bus.in_valid = 1'b0;
      take_word("stall");

      // out_ready in ACCUM mid-word has no effect
      exp_q.push_back(32'h0000_0402);
      send_beat(6'd1, 1'b0);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("accum_rdy_word", bus.out_word, 32'h0000_0002);
      check("accum_rdy_count", {26'd0, bus.out_count}, 32'd1);
      send_beat(6'd10, 1'b1);
      check_held("accum_rdy", 6'd1, 6'd2, 1'b0, 1'b0);
      take_word("accum_rdy");

      // reset mid-word discards it, asynchronously
      send_beat(6'd7, 1'b0);
      check("pre_rst_word", bus.out_word, 32'h0000_0080);
      #2 rst_n = 1'b0;
      #1 check_idle("mid_rst");
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back(32'h0000_0200);
      send_beat(6'd9, 1'b1);
      check_held("after_rst", 6'd9, 6'd1, 1'b0, 1'b0);

      // reset while holding drops the word
      #2 rst_n = 1'b0;
      #1 check_idle("hold_rst");
      check("hold_rst_state", {31'd0, dbg_state}, {31'd0, ACCUM});
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_idle("post_hold_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/bit_position_decoder.md
BIT_POSITION_DECODER -- requirements
Module: bit_position_decoder

Interface
REQ-001 Parameter: WIDTH, default 32, number of bits in the assembled word.
REQ-002 Parameter: POS_W, default 6, width of a bit position; the value WIDTH (32) is the "no bit set" code.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: in_valid  input  1  position beat offered.
REQ-006 Port: in_ready  output  1  block accepts a beat this cycle.
REQ-007 Port: in_pos  input  POS_W  bit position of the beat.
REQ-008 Port: in_last  input  1  beat closes the current word.
REQ-009 Port: out_valid  output  1  assembled word available.
REQ-010 Port: out_ready  input  1  consumer takes the word.
REQ-011 Port: out_word  output  WIDTH  assembled bit vector.
REQ-012 Port: out_min_pos  output  POS_W  lowest set position in out_word; 32 if none.
REQ-013 Port: out_count  output  POS_W  number of distinct set bits in out_word.
REQ-014 Port: out_dup  output  1  a position was received more than once in this word.
REQ-015 Port: out_range_err  output  1  a position greater than 32 was received in this word.

Function
REQ-016 The block SHALL have two states: ACCUM and HOLD.
REQ-017 in_ready SHALL be 1 in ACCUM and 0 in HOLD; out_valid SHALL be 1 in HOLD and 0 in ACCUM.
REQ-018 A beat SHALL be accepted when in_valid and in_ready are both 1 on a rising edge.
REQ-019 An accepted in_pos below 32 SHALL set that bit in the accumulator.
REQ-020 When that bit was previously clear, out_count SHALL increment by 1 and out_min_pos SHALL update to min(out_min_pos, in_pos).
REQ-021 When that bit was already set, the word SHALL be unchanged and the sticky out_dup SHALL be set.
REQ-022 An accepted in_pos equal to 32 SHALL leave the accumulator unchanged (empty marker).
REQ-023 An accepted in_pos above 32 SHALL leave the accumulator unchanged and SHALL set the sticky out_range_err.
REQ-024 An accepted beat with in_last=1 SHALL be applied, then the state SHALL move to HOLD; out_valid SHALL rise on the cycle after acceptance (latency 1).
REQ-025 In HOLD, out_word, out_min_pos, out_count, out_dup and out_range_err SHALL stay stable until out_ready=1.
REQ-026 On an out_valid and out_ready handshake, the block SHALL clear all outputs to their reset values and return to ACCUM; in_ready SHALL rise on the following cycle.
REQ-027 In ACCUM, the outputs SHALL show the running partial word; consumers SHALL use them only while out_valid=1.
REQ-028 out_ready while in ACCUM SHALL have no effect.

Reset
REQ-029 While rst_n=0, the block SHALL be in ACCUM with out_word=0, out_min_pos=32, out_count=0, out_dup=0 and out_range_err=0.
REQ-030 While rst_n=0, out_valid=0 and in_ready=1, independent of clk.
REQ-031 Reset asserted mid-word or in HOLD SHALL discard the partial or held word with no output handshake.
REQ-032 The first beat accepted after reset release SHALL start a new word.

Structure
REQ-033 A shared package SHALL hold the WIDTH and POS_W defaults, the NO_BIT constant (32) and the state enumeration (ACCUM, HOLD).
REQ-034 The block SHALL be one module with no sub-modules.
REQ-035 The reverse direction (lowest-set-bit detection) SHALL reuse NO_BIT from the same package.

Verification
REQ-036 Scenario: beats 12, 28(last) -> out_word=0x1000_1000, out_min_pos=12, out_count=2, out_dup=0.
REQ-037 Scenario: beats 28, 4, 12(last) -> out_word=0x1000_1010, out_min_pos=4, out_count=3.
REQ-038 Scenario: single beat 32(last) -> out_word=0, out_min_pos=32, out_count=0; then beats 5, 5(last) -> out_word=0x20, out_count=1, out_dup=1.
REQ-039 Scenario: beats 40, 0(last) -> out_word=0x1, out_range_err=1.
REQ-040 Scenario: out_ready held 0 for 3 cycles in HOLD -> outputs stable, in_ready=0; out_ready=1 -> outputs cleared next cycle, in_ready=1.
REQ-041 Scenario: rst_n pulsed low after beat 7, then beats 9(last) -> out_word=0x200, out_count=1.
